// File: rtl/cache_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) used by the cache refill arbiter.
// The master modport is the arbiter side, the slave modport the memory side.
interface cache_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [3:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between the ICache and
// DCache line-refill ports. One INCR burst per refill; beats are collected
// into a line buffer and handed back to the winner as a single ret_valid.
// Optional macro AXI_RD_ERR_CHK_EN adds a sticky rd_err output flagging
// non-OKAY responses and misplaced rlast.
module cache_rd_arbiter #(
    parameter int         LINE_WORD_NUM = 4,
    parameter int         DATA_WIDTH    = 32,
    parameter logic [3:0] ICACHE_ID     = 4'd0,
    parameter logic [3:0] DCACHE_ID     = 4'd1
) (
    input  logic                                clk,
    input  logic                                resetn,

    input  logic                                i_rd_req,
    input  logic [31:0]                         i_rd_addr,
    output logic                                i_rd_rdy,
    output logic                                i_ret_valid,
    output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] i_ret_data,

    input  logic                                d_rd_req,
    input  logic [31:0]                         d_rd_addr,
    output logic                                d_rd_rdy,
    output logic                                d_ret_valid,
    output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] d_ret_data,

`ifdef AXI_RD_ERR_CHK_EN
    output logic                                rd_err,
`endif

    cache_rd_arbiter_if.master                  axi
);

    localparam int CNT_W = $clog2(LINE_WORD_NUM);
    localparam int OFF_W = $clog2(LINE_WORD_NUM * 4);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORD_NUM - 1);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                              state_reg;
    state_t                              state_next;
    // Current grant; it also serves as last_grant for the next tie-break
    // (0 = ICache, 1 = DCache).
    logic                                grant_d_reg;
    logic                                grant_d_next;
    logic [31:0]                         araddr_reg;
    logic [31:0]                         sel_addr;
    logic [CNT_W-1:0]                    beat_cnt_reg;
    logic                                any_req;
    logic                                arb_fire;
    logic                                ar_fire;
    logic                                r_fire;
    logic [LINE_WORD_NUM*DATA_WIDTH-1:0] line_data;

    assign any_req  = i_rd_req | d_rd_req;
    assign arb_fire = (state_reg == IDLE) && any_req;
    assign ar_fire  = (state_reg == AR) && axi.arready;
    assign r_fire   = (state_reg == R) && axi.rvalid;

    // Winner of an IDLE arbitration: a tie goes to whoever was not served last
    always_comb begin
        grant_d_next = d_rd_req;
        if (i_rd_req && d_rd_req) begin
            grant_d_next = ~grant_d_reg;
        end
    end

    assign sel_addr = grant_d_next ? d_rd_addr : i_rd_addr;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake/return strobes
    always_comb begin
        state_next  = state_reg;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = AR;
                end
            end
            AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    i_rd_rdy   = ~grant_d_reg;
                    d_rd_rdy   = grant_d_reg;
                    state_next = R;
                end
            end
            R: begin
                axi.rready = 1'b1;
                if (axi.rvalid && axi.rlast) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                i_ret_valid = ~grant_d_reg;
                d_ret_valid = grant_d_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch grant and line-aligned address at arbitration; held through AR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_d_reg <= 1'b0;
            araddr_reg  <= '0;
        end else if (arb_fire) begin
            grant_d_reg <= grant_d_next;
            araddr_reg  <= {sel_addr[31:OFF_W], {OFF_W{1'b0}}};
        end
    end

    assign axi.arid    = grant_d_reg ? DCACHE_ID : ICACHE_ID;
    assign axi.araddr  = araddr_reg;
    assign axi.arlen   = 8'(LINE_WORD_NUM - 1);
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;

    // Beat index within the line; wraps naturally since the line is 2^n words
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt_reg <= '0;
        end else if (ar_fire) begin
            beat_cnt_reg <= '0;
        end else if (r_fire) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
    end

    // Line buffer: one register per word, written by the beat that lands on it
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORD_NUM; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;

            // Capture rdata when the current beat targets this word
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    word_reg <= '0;
                end else if (r_fire && (beat_cnt_reg == CNT_W'(gi))) begin
                    word_reg <= axi.rdata;
                end
            end

            assign line_data[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    endgenerate

    // Both caches see the buffer; only the winner's ret_valid qualifies it
    assign i_ret_data = line_data;
    assign d_ret_data = line_data;

`ifdef AXI_RD_ERR_CHK_EN
    logic rd_err_reg;

    // Sticky error: non-OKAY beat, or rlast not on the final word of the line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_err_reg <= 1'b0;
        end else if (r_fire && ((axi.rresp != 2'b00) ||
                                (axi.rlast && (beat_cnt_reg != LAST_BEAT)))) begin
            rd_err_reg <= 1'b1;
        end
    end

    assign rd_err = rd_err_reg;

    // rid is deliberately ignored: only one burst is ever in flight
    logic unused_rid;
    assign unused_rid = ^axi.rid;
`else
    // rid and rresp are not inspected when error checking is compiled out
    logic unused_axi;
    assign unused_axi = ^{axi.rid, axi.rresp};
`endif

endmodule

// File: doc/cache_rd_arbiter.md
Name: cache_rd_arbiter

Overview:
- Shares one AXI4 read master between the ICache and DCache line-refill ports.
- Each cache raises rd_req/rd_addr while in its miss state and waits for a one-cycle rd_rdy, then a one-cycle ret_valid carrying the whole line.
- This block arbitrates round-robin, issues one INCR burst per refill, assembles the beats into a line buffer and returns the line to the winner.
- Uncached traffic uses a separate path and is not handled here.

Parameters:
- LINE_WORD_NUM, 4, words per cache line (power of 2, 2..16).
- DATA_WIDTH, 32, word and R-channel width.
- ICACHE_ID, 4'd0, arid used for ICache refills.
- DCACHE_ID, 4'd1, arid used for DCache refills.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_rd_req  in  1  ICache refill request, level, held until i_rd_rdy.
- i_rd_addr  in  32  ICache refill address.
- i_rd_rdy  out  1  ICache request accepted (1-cycle pulse).
- i_ret_valid  out  1  ICache line valid (1-cycle pulse).
- i_ret_data  out  LINE_WORD_NUM*DATA_WIDTH  ICache line; word 0 at LSBs.
- d_rd_req, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_data: same as the i_ ports, for the DCache.
- arid  out  4  AR id.
- araddr  out  32  AR address.
- arlen  out  8  burst length.
- arsize  out  3  beat size.
- arburst  out  2  burst type.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  DATA_WIDTH  R data.
- rresp  in  2  R response.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset: asynchronous and active-low. All registers clear immediately: state=IDLE, arvalid=0, rready=0, all rd_rdy/ret_valid=0, beat_cnt=0, line buffer=0, last_grant=ICache (so the first tie goes to the DCache).
- Reset mid-burst: the transaction is abandoned and no ret_valid is produced.
- FSM has four states: IDLE, AR, R, DONE.
- IDLE:
  - If any rd_req is high, register grant (tie-break: the requester that is not last_grant), latch araddr = rd_addr with the low log2(LINE_WORD_NUM*4) bits zeroed, update last_grant, then go to AR.
  - Otherwise stay in IDLE.
- AR:
  - arvalid=1. arid = granted ID, arlen = LINE_WORD_NUM-1, arsize = 3'b010, arburst = 2'b01 (INCR).
  - All AR fields stay stable until the handshake.
  - On arvalid&&arready: pulse the granted rd_rdy for exactly that cycle (combinational with arready), clear beat_cnt, go to R.
- R:
  - rready=1.
  - Each rvalid cycle writes rdata into word beat_cnt of the line buffer and increments beat_cnt. beat_cnt wraps modulo LINE_WORD_NUM.
  - rvalid gaps of any length are tolerated.
  - On the rvalid&&rlast beat, go to DONE.
  - rid is not checked.
- DONE:
  - Granted ret_valid=1 for one cycle. ret_data = line buffer, held stable until the next R-state write.
  - The non-granted cache sees ret_valid=0.
  - Next state is IDLE.
- Latency: rd_req to arvalid is 1 cycle (IDLE→AR). rlast beat to ret_valid is 1 cycle. Minimum back-to-back request spacing is one IDLE cycle.
- A losing requester keeps rd_req high and is served at the next IDLE. rd_req changes outside IDLE are ignored.
- A request dropped before grant is not served.
- Only one outstanding AR at a time, so at most one burst is in flight.

Optional Feature:
- Macro: AXI_RD_ERR_CHK_EN.
- With the macro defined:
  - Adds output rd_err (1 bit, sticky, cleared only by reset).
  - rd_err is set if any accepted beat has rresp != 2'b00, or if rlast arrives when beat_cnt != LINE_WORD_NUM-1.
  - The line is still returned (DONE as normal).
- Without the macro: no rd_err port and no check logic.

Test Plan:
- Single ICache refill (LINE_WORD_NUM=4):
  - Stimulus: i_rd_addr=0x1FC0_0014; beats 0x11, 0x22, 0x33, 0x44 with rlast on the 4th.
  - Required: araddr=0x1FC0_0010, arlen=3, arid=0, arsize=2, arburst=1; i_rd_rdy one cycle at the AR handshake; i_ret_valid one cycle later with line 0x00000044_00000033_00000022_00000011; d_ret_valid stays 0.
- Simultaneous requests after reset:
  - Stimulus: i_rd_req=d_rd_req=1 with addresses 0x100 and 0x200.
  - Required: first AR is 0x200 with arid=1, then after that DONE, 0x100 with arid=0.
- Round-robin fairness:
  - Stimulus: both caches re-request immediately after each return, for 4 refills.
  - Required: grants alternate D, I, D, I.
- arready stalled 5 cycles:
  - Required: arvalid held high with araddr/arlen constant; rd_rdy only in the handshake cycle.
- rvalid gaps:
  - Stimulus: beats spaced 0, 3, 0, 7 idle cycles.
  - Required: correct line, and ret_valid only after rlast.
- Reset asserted during R after 2 beats:
  - Required: immediately arvalid=0, rready=0, no ret_valid; a fresh request after release completes normally.
- AXI_RD_ERR_CHK_EN defined:
  - Stimulus: 3rd beat with rresp=2'b10 → rd_err=1 and stays 1; the line is still returned.
  - Stimulus: early rlast on the 2nd beat → rd_err=1.
